// File: rtl/rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : rx_controller
// Description : 8N1 serial receiver with a two-flop input synchronizer,
//               mid-bit sampling, frame-error detection and wait-for-idle
//               recovery after a broken stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_controller #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_active,
    output logic       o_rx_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_START     = 3'd1;
    localparam logic [2:0] c_S_DATA      = 3'd2;
    localparam logic [2:0] c_S_STOP      = 3'd3;
    localparam logic [2:0] c_S_WAIT_HIGH = 3'd4;

    logic [1:0]       r_sync;
    logic             r_rx_s;
    logic [2:0]       r_state;
    logic [2:0]       w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_tick;
    logic             w_valid_nxt;
    logic             w_ferr_nxt;
    logic             w_active_nxt;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_active;
    logic             r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx_serial};
        end
    end

    assign r_rx_s = r_sync[1];

    // The start bit is checked half a period in; every later sample is a full period apart.
    assign w_tick = (r_state == c_S_START) ? (r_cnt == c_HALF_LAST)
                                           : (r_cnt == c_BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = c_S_START;
                end
            end
            c_S_START: begin
                if (w_tick) begin
                    w_state_next = r_rx_s ? c_S_IDLE : c_S_DATA;
                end
            end
            c_S_DATA: begin
                if (w_tick && (r_bit_idx == 3'd7)) begin
                    w_state_next = c_S_STOP;
                end
            end
            c_S_STOP: begin
                if (w_tick) begin
                    w_state_next = r_rx_s ? c_S_IDLE : c_S_WAIT_HIGH;
                end
            end
            c_S_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state_next = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_valid_nxt  = (r_state == c_S_STOP) && w_tick && r_rx_s;
        w_ferr_nxt   = (r_state == c_S_STOP) && w_tick && !r_rx_s;
        w_active_nxt = (w_state_next != c_S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                c_S_START, c_S_DATA, c_S_STOP: begin
                    r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase

            // LSB arrives first, so shifting in from the top leaves bit 0 at the bottom.
            if (r_state == c_S_DATA) begin
                if (w_tick) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                    r_shift   <= {r_rx_s, r_shift[7:1]};
                end
            end else begin
                r_bit_idx <= 3'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_rx_active <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
            r_rx_active <= w_active_nxt;
            if (w_valid_nxt) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign o_rx_data      = r_rx_data;
    assign o_rx_valid     = r_rx_valid;
    assign o_rx_active    = r_rx_active;
    assign o_rx_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/rx_controller.md
RX_CONTROLLER -- requirements
Module: rx_controller

Interface
REQ-001 Parameter: CLKS_PER_BIT, 16, clocks per serial bit period; legal values >= 4.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_rx_serial  input  1  asynchronous serial line; idle high; 8N1 frame (start 0, 8 data bits LSB first, stop 1).
REQ-005 o_rx_data  output  8  last correctly framed byte, held until the next good frame.
REQ-006 o_rx_valid  output  1  one-cycle pulse: new byte on o_rx_data.
REQ-007 o_rx_active  output  1  high while a frame is being received.
REQ-008 o_rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Function
REQ-009 i_rx_serial SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-010 States SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; a bit-period counter sized $clog2(CLKS_PER_BIT) and a 3-bit bit index.
REQ-011 IDLE: counter and index held 0; on edge E0 where rx_s==0, go to START, o_rx_active<=1.
REQ-012 If i_rx_serial falls before edge N, E0 SHALL be edge N+2.
REQ-013 START: at E0+CLKS_PER_BIT/2 (integer division) sample rx_s; 0 -> DATA, counter cleared; 1 -> glitch, go to IDLE, o_rx_active<=0, no valid, no error.
REQ-014 DATA: sample rx_s at E0+CLKS_PER_BIT/2+k*CLKS_PER_BIT for k=1..8 into bit k-1 of a shift/assembly register (LSB first); after k=8 go to STOP.
REQ-015 STOP: sample rx_s at E0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-016 Stop sample 1 -> o_rx_data<=assembled byte, o_rx_valid<=1 for exactly the following cycle, o_rx_active<=0, go to IDLE.
REQ-017 Stop sample 0 -> o_rx_frame_err<=1 for exactly the following cycle, o_rx_data unchanged, no valid, go to WAIT_HIGH.
REQ-018 WAIT_HIGH: o_rx_active stays 1; go to IDLE (o_rx_active<=0) on first edge with rx_s==1; a held-low line SHALL never start a new frame.
REQ-019 Returning to IDLE at mid-stop SHALL allow a start bit immediately following the stop bit (zero idle gap) to be received.
REQ-020 o_rx_valid and o_rx_frame_err SHALL never be high in the same cycle and never high for more than one consecutive cycle.
REQ-021 No buffering: a new good frame overwrites o_rx_data regardless of whether the previous byte was consumed.
REQ-022 Line changes within a bit period other than at sample edges SHALL have no effect.

Reset
REQ-023 reset high SHALL immediately force state IDLE, counter 0, index 0, assembly register 0, synchronizer 1s.
REQ-024 Reset values: o_rx_data=8'h00, o_rx_valid=0, o_rx_active=0, o_rx_frame_err=0.
REQ-025 Reset mid-frame SHALL discard the partial byte; reception resumes with the first falling edge after reset release.

Verification (CLKS_PER_BIT=16)
REQ-026 Reset held, line high 100 cycles -> all outputs 0, no pulses.
REQ-027 Frame 0xA5, 16 clocks/bit, line falls before edge N -> single o_rx_valid in cycle after edge N+154, o_rx_data=0xA5, o_rx_frame_err=0.
REQ-028 Line low 4 cycles then high -> o_rx_active high ~8 cycles then 0, no valid, no error, o_rx_data unchanged.
REQ-029 After 0xA5, frame 0x3C with stop bit low and line low 40 more cycles -> one o_rx_frame_err pulse, o_rx_data stays 0xA5, o_rx_active held until line high; next 0x5A frame received correctly.
REQ-030 Back-to-back frames 0x00 then 0xFF, no idle gap -> two valid pulses exactly 160 cycles apart, data 0x00 then 0xFF.
REQ-031 Reset asserted during data bit 4 of a frame -> o_rx_active and o_rx_data 0 same cycle; subsequent frame 0x81 received with one valid pulse.
